// File: rtl/mdr_unit.sv
// Memory data register with a handshaked data-memory port: wait states, byte lanes and
// a wait-cycle timeout. One command at a time; completion reported by done or err.
module mdr_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             c_bus,
  input  logic                          c_load,
  input  logic                          dmem_read,
  input  logic                          dmem_write,
  input  logic                          byte_mode,
  input  logic [$clog2(DATA_W/8)-1:0]   byte_sel,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rvalid,
  input  logic                          mem_wready,
  output logic                          mem_rd_req,
  output logic                          mem_wr_req,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_be,
  output logic [DATA_W-1:0]             mdr_out,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned SW = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires on the edge where the counter would reach TIMEOUT.
  localparam logic [CW-1:0] LastWait = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            byte_mode_q;
  logic [SW-1:0]   byte_sel_q;

  logic [DATA_W-1:0] rd_lane;
  logic [NB-1:0]     be_onehot;
  logic [DATA_W-1:0] wr_byte;
  logic              timeout_hit;

  always_comb begin
    rd_lane   = '0;
    be_onehot = '0;
    for (int i = 0; i < NB; i++) begin
      if (byte_sel_q == SW'(i)) rd_lane[7:0] = mem_rdata[8*i +: 8];
      if (byte_sel == SW'(i)) be_onehot[i] = 1'b1;
    end
  end

  assign wr_byte     = {NB{mdr_out[7:0]}};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LastWait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      byte_mode_q <= 1'b0;
      byte_sel_q  <= '0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      mdr_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dmem_read) begin
            byte_mode_q <= byte_mode;
            byte_sel_q  <= byte_sel;
            mem_rd_req  <= 1'b1;
            busy        <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StRdWait;
          end else if (dmem_write) begin
            mem_wdata  <= byte_mode ? wr_byte : mdr_out;
            mem_be     <= byte_mode ? be_onehot : '1;
            mem_wr_req <= 1'b1;
            busy       <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StWrWait;
          end else if (c_load) begin
            mdr_out <= c_bus;
            done    <= 1'b1;
          end
        end
        StRdWait: begin
          if (mem_rvalid) begin
            mdr_out    <= byte_mode_q ? rd_lane : mem_rdata;
            mem_rd_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_q    <= StIdle;
          end else if (timeout_hit) begin
            mem_rd_req <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StWrWait: begin
          if (mem_wready) begin
            mem_wr_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_q    <= StIdle;
          end else if (timeout_hit) begin
            mem_wr_req <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_unit.sv
// Lockstep bench for 16- and 32-bit mdr_unit instances against a transaction-level model.
module tb_mdr_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c_bus, mem_rdata;
  logic        c_load, dmem_read, dmem_write, byte_mode, mem_rvalid, mem_wready;
  logic [1:0]  byte_sel;

  logic [15:0] mdr16, wdata16;
  logic [1:0]  be16;
  logic        rdreq16, wrreq16, busy16, done16, err16;
  logic [31:0] mdr32, wdata32;
  logic [3:0]  be32;
  logic        rdreq32, wrreq32, busy32, done32, err32;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] m16, m32;  // model MDR contents

  always #5 clk = ~clk;

  mdr_unit #(.DATA_W(16), .TIMEOUT(TO)) dut16 (
    .clk(clk), .rst(rst), .c_bus(c_bus[15:0]), .c_load(c_load), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .byte_mode(byte_mode), .byte_sel(byte_sel[0]),
    .mem_rdata(mem_rdata[15:0]), .mem_rvalid(mem_rvalid), .mem_wready(mem_wready),
    .mem_rd_req(rdreq16), .mem_wr_req(wrreq16), .mem_wdata(wdata16), .mem_be(be16),
    .mdr_out(mdr16), .busy(busy16), .done(done16), .err(err16)
  );

  mdr_unit #(.DATA_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst), .c_bus(c_bus), .c_load(c_load), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .byte_mode(byte_mode), .byte_sel(byte_sel),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wready(mem_wready),
    .mem_rd_req(rdreq32), .mem_wr_req(wrreq32), .mem_wdata(wdata32), .mem_be(be32),
    .mdr_out(mdr32), .busy(busy32), .done(done32), .err(err32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read result: whole word, or one zero-extended byte lane.
  function automatic logic [31:0] rd_exp(input logic [31:0] d, input bit bm, input int sel,
                                         input int nb);
    logic [31:0] m;
    m = (nb == 2) ? (d & 32'h0000_FFFF) : d;
    if (bm) return (m >> (8 * sel)) & 32'hFF;
    return m;
  endfunction

  function automatic logic [31:0] wd_exp(input logic [31:0] mdr, input bit bm, input int nb);
    logic [31:0] r;
    if (!bm) return mdr;
    r = 0;
    for (int i = 0; i < nb; i++) r = r | ((mdr & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] be_exp(input bit bm, input int sel, input int nb);
    if (bm) return 32'd1 << sel;
    return (32'd1 << nb) - 1;
  endfunction

  task automatic chk_all(input string tag, input logic rd, input logic wr, input logic bsy,
                         input logic dn, input logic er);
    check({tag, ".mdr16"}, {16'h0, mdr16}, m16);
    check({tag, ".mdr32"}, mdr32, m32);
    check({tag, ".ctl16"}, {27'h0, rdreq16, wrreq16, busy16, done16, err16},
          {27'h0, rd, wr, bsy, dn, er});
    check({tag, ".ctl32"}, {27'h0, rdreq32, wrreq32, busy32, done32, err32},
          {27'h0, rd, wr, bsy, dn, er});
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] w16, input logic [31:0] b16,
                        input logic [31:0] w32, input logic [31:0] b32);
    check({tag, ".wd16"}, {16'h0, wdata16}, w16);
    check({tag, ".be16"}, {30'h0, be16}, b16);
    check({tag, ".wd32"}, wdata32, w32);
    check({tag, ".be32"}, {28'h0, be32}, b32);
  endtask

  task automatic rd_txn(input bit bm, input logic [1:0] sel, input int waits,
                        input logic [31:0] data, input bit pile);
    dmem_read = 1'b1; byte_mode = bm; byte_sel = sel; mem_rvalid = 1'b0;
    if (pile) begin
      dmem_write = 1'b1; c_load = 1'b1; c_bus = ~data;
    end
    step();
    // Flip qualifiers so the DUT must use the values latched at the command edge.
    dmem_read = 1'b0; dmem_write = 1'b0; c_load = pile; byte_mode = ~bm; byte_sel = ~sel;
    chk_all("rd_e0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (waits >= TO) begin
      c_load = 1'b0;
      for (int k = 1; k <= TO; k++) begin
        mem_rdata = $urandom;
        step();
        if (k < TO) chk_all("rd_to_wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        else chk_all("rd_to_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      // Stray rvalid while idle must not touch the MDR.
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      step();
      mem_rvalid = 1'b0;
      chk_all("rd_to_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < waits; k++) begin
        mem_rdata = $urandom;
        step();
        chk_all("rd_wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      c_load = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
      step();
      mem_rvalid = 1'b0;
      m16 = rd_exp(data, bm, int'(sel[0]), 2);
      m32 = rd_exp(data, bm, int'(sel), 4);
      chk_all("rd_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_all("rd_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wr_txn(input bit bm, input logic [1:0] sel, input int waits);
    logic [31:0] w16, b16, w32, b32;
    w16 = wd_exp(m16, bm, 2); b16 = be_exp(bm, int'(sel[0]), 2);
    w32 = wd_exp(m32, bm, 4); b32 = be_exp(bm, int'(sel), 4);
    dmem_write = 1'b1; byte_mode = bm; byte_sel = sel; mem_wready = 1'b0;
    step();
    dmem_write = 1'b0; byte_mode = ~bm; byte_sel = ~sel;
    chk_all("wr_e0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_wr("wr_e0", w16, b16, w32, b32);
    if (waits >= TO) begin
      for (int k = 1; k <= TO; k++) begin
        step();
        if (k < TO) begin
          chk_all("wr_to_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
          chk_wr("wr_to_wait", w16, b16, w32, b32);
        end else begin
          chk_all("wr_to_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
      end
      step();
      chk_all("wr_to_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < waits; k++) begin
        step();
        chk_all("wr_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_wr("wr_wait", w16, b16, w32, b32);
      end
      mem_wready = 1'b1;
      step();
      mem_wready = 1'b0;
      chk_all("wr_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_all("wr_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic cload(input logic [31:0] v);
    c_bus = v; c_load = 1'b1;
    step();
    c_load = 1'b0;
    m16 = v & 32'hFFFF; m32 = v;
    chk_all("cload", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("cload_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; c_bus = '0; mem_rdata = '0; c_load = 1'b0; dmem_read = 1'b0;
    dmem_write = 1'b0; byte_mode = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
    byte_sel = '0; m16 = '0; m32 = '0;
    #3;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_wr("reset", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();

    rd_txn(1'b0, 2'd0, 0, 32'hDEAD_BEEF, 1'b0);      // zero-wait word read
    rd_txn(1'b1, 2'd1, 3, 32'h1234_A55A, 1'b0);      // byte lane 1, 3 waits
    cload(32'h5566_1234);
    wr_txn(1'b1, 2'd1, 2);                           // 3434 / be 10
    rd_txn(1'b0, 2'd0, TO, 32'hFFFF_FFFF, 1'b0);     // read timeout
    rd_txn(1'b0, 2'd0, TO - 1, 32'h0BAD_CAFE, 1'b0); // handshake on the timeout edge wins
    wr_txn(1'b0, 2'd0, TO);                          // write timeout
    wr_txn(1'b0, 2'd0, TO - 1);
    rd_txn(1'b0, 2'd0, 3, 32'h7777_4242, 1'b1);      // all commands at once, c_load while busy
    rd_txn(1'b1, 2'd3, 1, 32'hC3B2_A190, 1'b0);      // top lane of the wide instance

    // Asynchronous reset in the middle of a read.
    dmem_read = 1'b1; byte_mode = 1'b0;
    step();
    dmem_read = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    m16 = '0; m32 = '0;
    chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_wr("rst_mid", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    step();
    mem_rvalid = 1'b0;
    chk_all("rst_stray", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_txn(1'b0, 2'd0, 2, 32'h2468_ACE0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      int kind, waits;
      bit bm;
      logic [1:0] sel;
      kind = $urandom_range(0, 2);
      bm = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      case (kind)
        0: rd_txn(bm, sel, waits, $urandom, 1'($urandom_range(0, 1)));
        1: wr_txn(bm, sel, waits);
        default: cload($urandom);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mdr_unit.md
# mdr_unit

Parametrised memory data register for the datapath. It replaces the single-cycle read-or-C-bus register with a handshaked data-memory interface that tolerates wait states, supports byte-lane reads and writes, and detects memory timeouts. It sits between the C bus, the data memory and the B-bus source mux. The control unit issues one command at a time and waits for `done` or `err`.

## Interface
Parameters:
- `DATA_W`, default 16: register and bus width; a multiple of 8, at least 16.
- `TIMEOUT`, default 15: maximum number of read or write wait cycles before `err`; 0 disables the timeout.

Ports (`SW = $clog2(DATA_W/8)`):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `c_bus`  in  DATA_W  value from the C bus.
- `c_load`  in  1  load `c_bus` into the MDR.
- `dmem_read`  in  1  command: read memory into the MDR.
- `dmem_write`  in  1  command: write the MDR to memory.
- `byte_mode`  in  1  command qualifier: single-byte access.
- `byte_sel`  in  SW  byte lane used when `byte_mode` is set.
- `mem_rdata`  in  DATA_W  memory read data.
- `mem_rvalid`  in  1  `mem_rdata` is valid this cycle.
- `mem_wready`  in  1  memory accepts the write this cycle.
- `mem_rd_req`  out  1  read request, registered.
- `mem_wr_req`  out  1  write request, registered.
- `mem_wdata`  out  DATA_W  write data, registered.
- `mem_be`  out  DATA_W/8  byte enables, registered.
- `mdr_out`  out  DATA_W  MDR contents.
- `busy`  out  1  a memory transaction is in progress.
- `done`  out  1  one-cycle pulse: command completed.
- `err`  out  1  one-cycle pulse: timeout abort.

## Operation
States: IDLE, RD_WAIT, WR_WAIT.

IDLE:
- Commands are sampled only in IDLE. Priority is `dmem_read` > `dmem_write` > `c_load`; lower-priority commands asserted in the same cycle are dropped.
- `dmem_read`:
  - latch `byte_mode`/`byte_sel`
  - set `mem_rd_req`=1 and `busy`=1
  - go to RD_WAIT
- `dmem_write`:
  - drive `mem_wdata`: `mdr_out` in word mode; low byte of `mdr_out` replicated into every lane in byte mode
  - drive `mem_be`: all ones in word mode; one-hot(`byte_sel`) in byte mode
  - set `mem_wr_req`=1 and `busy`=1
  - go to WR_WAIT
- `c_load`: `mdr_out` <= `c_bus` (always full width); `done`=1 next cycle; stay in IDLE.

RD_WAIT:
- Hold `mem_rd_req`=1.
- On `mem_rvalid`:
  - word mode: `mdr_out` <= `mem_rdata`
  - byte mode: `mdr_out` <= zero-extended lane `byte_sel` of `mem_rdata`
  - drop `mem_rd_req` and `busy`, pulse `done`, go to IDLE
- A `mem_rvalid` seen outside RD_WAIT is ignored.

WR_WAIT:
- Hold `mem_wr_req`, `mem_wdata` and `mem_be` stable.
- On `mem_wready`: drop `mem_wr_req` and `busy`, pulse `done`, go to IDLE.

Timeout:
- The wait counter clears on entry to RD_WAIT or WR_WAIT and increments each cycle the handshake input is low.
- When it reaches `TIMEOUT`:
  - drop the request and `busy`, pulse `err` (not `done`), go to IDLE
  - `mdr_out` is unchanged
- A handshake arriving on the same edge the counter reaches `TIMEOUT` wins: completion, no `err`.

Commands asserted while `busy`=1 are ignored and are not queued.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0. Outputs `mdr_out`, `mem_wdata`, `mem_be`, `mem_rd_req`, `mem_wr_req`, `busy`, `done` and `err` are all 0. Reset mid-transaction drops the request in the same cycle.
- Edge E0 samples the command; the request and `busy` are high after E0.
- The earliest handshake is sampled at E1. `mdr_out`, `done` and request-low are all visible after E1. This gives a zero-wait read latency of 2 edges from command to data.
- Each wait cycle adds one edge.
- `c_load` latency is one edge.
- `done` and `err` are each high for exactly one cycle and are never high together.

## Test plan
- Reset, then word read with `mem_rdata`=16'hBEEF and `mem_rvalid` on the first cycle -> `mdr_out`=BEEF after 2 edges; `done` is a single pulse; `mem_rd_req` is high for exactly 1 cycle.
- Byte read with `byte_sel`=1, `mem_rdata`=16'hA55A and 3 wait cycles -> `mdr_out`=16'h00A5 on the 5th edge; `busy` is high for 4 cycles.
- `c_load` with `c_bus`=16'h1234, then a byte write with `byte_sel`=1 and `mem_wready` after 2 waits -> `mem_wdata`=16'h3434 and `mem_be`=2'b10 held stable throughout; `done` pulses once.
- Read with `mem_rvalid` never asserted, `TIMEOUT`=15 -> `err` pulses 15 cycles after the request rises; `mdr_out` is unchanged; no `done`.
- `dmem_read`, `dmem_write` and `c_load` asserted together, followed by `c_load` during `busy` -> only the read executes; `mdr_out` equals the read data and never equals `c_bus`.
- `rst` pulsed mid-RD_WAIT, with `DATA_W`=32 also exercised -> all outputs are 0 immediately; a later `mem_rvalid` is ignored and the next command works normally.
